// File: rtl/cache_tag_lookup_if.sv
// rtl/cache_tag_lookup_if.sv - request/response, fill and tag RAM signals of the tag lookup block
interface cache_tag_lookup_if #(
  parameter int SET_NUM = 128,
  parameter int TAG_W   = 20
);
  localparam int IW = $clog2(SET_NUM);
  localparam int EW = TAG_W + 2;

  logic             req_valid;
  logic             req_ready;
  logic [IW-1:0]    req_index;
  logic [TAG_W-1:0] req_tag;
  logic             req_write;

  logic             resp_valid;
  logic             resp_hit;
  logic [1:0]       resp_way;
  logic [1:0]       resp_victim_way;
  logic             resp_victim_dirty;
  logic [TAG_W-1:0] resp_victim_tag;

  logic             fill_valid;
  logic             fill_ready;
  logic [IW-1:0]    fill_index;
  logic [1:0]       fill_way;
  logic [TAG_W-1:0] fill_tag;
  logic             fill_dirty;

  logic             tag_en;
  logic [3:0]       tag_we;
  logic [IW-1:0]    tag_addr;
  logic [EW-1:0]    tag_wdata;
  logic [4*EW-1:0]  tag_rdata;

  modport master (
    output req_valid, req_index, req_tag, req_write,
    output fill_valid, fill_index, fill_way, fill_tag, fill_dirty,
    output tag_rdata,
    input  req_ready, fill_ready,
    input  resp_valid, resp_hit, resp_way, resp_victim_way, resp_victim_dirty, resp_victim_tag,
    input  tag_en, tag_we, tag_addr, tag_wdata
  );

  modport slave (
    input  req_valid, req_index, req_tag, req_write,
    input  fill_valid, fill_index, fill_way, fill_tag, fill_dirty,
    input  tag_rdata,
    output req_ready, fill_ready,
    output resp_valid, resp_hit, resp_way, resp_victim_way, resp_victim_dirty, resp_victim_tag,
    output tag_en, tag_we, tag_addr, tag_wdata
  );
endinterface

// File: rtl/cache_tag_lookup.sv
// rtl/cache_tag_lookup.sv - 4-way tag lookup with init sweep, tree pseudo-LRU victim and dirty update
module cache_tag_lookup #(
  parameter int SET_NUM = 128,
  parameter int TAG_W   = 20
) (
  input logic              clk,
  input logic              rst,
  cache_tag_lookup_if.slave bus
);
  localparam int IW = $clog2(SET_NUM);
  localparam int EW = TAG_W + 2;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_DIRTY} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    cnt_q, cnt_d;
  logic [2:0]       plru_q [SET_NUM];
  logic [2:0]       plru_d [SET_NUM];
  logic             resp_valid_q, resp_valid_d;
  logic             resp_hit_q, resp_hit_d;
  logic [1:0]       resp_way_q, resp_way_d;
  logic [1:0]       resp_vway_q, resp_vway_d;
  logic             resp_vdirty_q, resp_vdirty_d;
  logic [TAG_W-1:0] resp_vtag_q, resp_vtag_d;
  logic [1:0]       dirty_way_q, dirty_way_d;
  logic [IW-1:0]    dirty_idx_q, dirty_idx_d;
  logic [TAG_W-1:0] dirty_tag_q, dirty_tag_d;

  logic [EW-1:0]    entry [4];
  logic [3:0]       hit_vec;
  logic             hit_any, inv_any, needs_dirty;
  logic [1:0]       hit_way, inv_way, plru_vic, victim;
  logic [2:0]       plru_cur;
  logic             fill_fire, req_fire;

  // Bits {b2,b1,b0}: b0 selects the half, b1/b2 the way within the left/right half.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] r;
    r    = p;
    r[0] = ~w[1];
    if (!w[1]) r[1] = ~w[0];
    else       r[2] = ~w[0];
    return r;
  endfunction

  always_comb begin
    hit_vec  = '0;
    hit_way  = '0;
    hit_any  = 1'b0;
    inv_way  = '0;
    inv_any  = 1'b0;
    for (int w = 0; w < 4; w++) begin
      entry[w]   = bus.tag_rdata[w*EW +: EW];
      hit_vec[w] = entry[w][EW-1] && (entry[w][TAG_W-1:0] == bus.req_tag);
    end
    for (int w = 3; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit_any = 1'b1;
        hit_way = 2'(w);
      end
      if (!entry[w][EW-1]) begin
        inv_any = 1'b1;
        inv_way = 2'(w);
      end
    end
    plru_cur    = plru_q[bus.req_index];
    plru_vic    = plru_cur[0] ? (plru_cur[2] ? 2'd3 : 2'd2) : (plru_cur[1] ? 2'd1 : 2'd0);
    victim      = inv_any ? inv_way : plru_vic;
    needs_dirty = hit_any && bus.req_write && !entry[hit_way][EW-2];
  end

  assign fill_fire = (state_q == S_IDLE) && bus.fill_valid;
  assign req_fire  = (state_q == S_IDLE) && bus.req_valid && !bus.fill_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_INIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (cnt_q == IW'(SET_NUM - 1)) state_d = S_IDLE;
      S_IDLE:  if (req_fire && needs_dirty) state_d = S_DIRTY;
      S_DIRTY: state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Outputs are forced low while reset is held so the sweep does not appear during reset.
  always_comb begin
    bus.req_ready  = 1'b0;
    bus.fill_ready = 1'b0;
    bus.tag_en     = 1'b0;
    bus.tag_we     = '0;
    bus.tag_addr   = '0;
    bus.tag_wdata  = '0;
    if (rst) begin
      case (state_q)
        S_INIT: begin
          bus.tag_en   = 1'b1;
          bus.tag_we   = 4'hF;
          bus.tag_addr = cnt_q;
        end
        S_IDLE: begin
          bus.fill_ready = 1'b1;
          bus.req_ready  = !bus.fill_valid;
          if (bus.fill_valid) begin
            bus.tag_en    = 1'b1;
            bus.tag_we    = 4'b0001 << bus.fill_way;
            bus.tag_addr  = bus.fill_index;
            bus.tag_wdata = {1'b1, bus.fill_dirty, bus.fill_tag};
          end else if (bus.req_valid) begin
            bus.tag_en   = 1'b1;
            bus.tag_addr = bus.req_index;
          end
        end
        S_DIRTY: begin
          bus.tag_en    = 1'b1;
          bus.tag_we    = 4'b0001 << dirty_way_q;
          bus.tag_addr  = dirty_idx_q;
          bus.tag_wdata = {2'b11, dirty_tag_q};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d         = (state_q == S_INIT) ? cnt_q + 1'b1 : '0;
    plru_d        = plru_q;
    resp_valid_d  = req_fire;
    resp_hit_d    = resp_hit_q;
    resp_way_d    = resp_way_q;
    resp_vway_d   = resp_vway_q;
    resp_vdirty_d = resp_vdirty_q;
    resp_vtag_d   = resp_vtag_q;
    dirty_way_d   = dirty_way_q;
    dirty_idx_d   = dirty_idx_q;
    dirty_tag_d   = dirty_tag_q;
    if (fill_fire) begin
      plru_d[bus.fill_index] = plru_touch(plru_q[bus.fill_index], bus.fill_way);
    end else if (req_fire) begin
      if (hit_any) plru_d[bus.req_index] = plru_touch(plru_cur, hit_way);
      resp_hit_d    = hit_any;
      resp_way_d    = hit_way;
      resp_vway_d   = victim;
      resp_vdirty_d = entry[victim][EW-1] && entry[victim][EW-2];
      resp_vtag_d   = entry[victim][TAG_W-1:0];
      dirty_way_d   = hit_way;
      dirty_idx_d   = bus.req_index;
      dirty_tag_d   = entry[hit_way][TAG_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_way_q    <= '0;
      resp_vway_q   <= '0;
      resp_vdirty_q <= 1'b0;
      resp_vtag_q   <= '0;
      dirty_way_q   <= '0;
      dirty_idx_q   <= '0;
      dirty_tag_q   <= '0;
      for (int s = 0; s < SET_NUM; s++) plru_q[s] <= '0;
    end else begin
      cnt_q         <= cnt_d;
      resp_valid_q  <= resp_valid_d;
      resp_hit_q    <= resp_hit_d;
      resp_way_q    <= resp_way_d;
      resp_vway_q   <= resp_vway_d;
      resp_vdirty_q <= resp_vdirty_d;
      resp_vtag_q   <= resp_vtag_d;
      dirty_way_q   <= dirty_way_d;
      dirty_idx_q   <= dirty_idx_d;
      dirty_tag_q   <= dirty_tag_d;
      for (int s = 0; s < SET_NUM; s++) plru_q[s] <= plru_d[s];
    end
  end

  assign bus.resp_valid        = resp_valid_q;
  assign bus.resp_hit          = resp_hit_q;
  assign bus.resp_way          = resp_way_q;
  assign bus.resp_victim_way   = resp_vway_q;
  assign bus.resp_victim_dirty = resp_vdirty_q;
  assign bus.resp_victim_tag   = resp_vtag_q;
endmodule

// File: tb/tb_cache_tag_lookup.sv
// tb/tb_cache_tag_lookup.sv - scoreboard bench for cache_tag_lookup with behavioural cache model
module tb_cache_tag_lookup;
  localparam int SET_NUM = 128;
  localparam int TAG_W   = 20;
  localparam int IW      = 7;
  localparam int EW      = TAG_W + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_tag_lookup_if #(.SET_NUM(SET_NUM), .TAG_W(TAG_W)) bus ();
  cache_tag_lookup #(.SET_NUM(SET_NUM), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  // Tag RAMs: combinational read, write on clock edge.
  logic [EW-1:0] ram [SET_NUM][4];
  assign bus.tag_rdata = {ram[bus.tag_addr][3], ram[bus.tag_addr][2], ram[bus.tag_addr][1], ram[bus.tag_addr][0]};
  always @(posedge clk)
    if (bus.tag_en)
      for (int w = 0; w < 4; w++)
        if (bus.tag_we[w]) ram[bus.tag_addr][w] <= bus.tag_wdata;

  // Reference model: per-set line state plus tree pointers (root, left pair, right pair).
  logic             mv [SET_NUM][4];
  logic             md [SET_NUM][4];
  logic [TAG_W-1:0] mt [SET_NUM][4];
  int               root [SET_NUM];
  int               lft  [SET_NUM];
  int               rgt  [SET_NUM];

  typedef struct {
    logic             hit;
    logic [1:0]       way;
    logic [1:0]       vway;
    logic             vdirty;
    logic [TAG_W-1:0] vtag;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input bit ok, input string act, input string req);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %s, expected %s", name, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < SET_NUM; s++) begin
      root[s] = 0; lft[s] = 0; rgt[s] = 0;
      for (int w = 0; w < 4; w++) begin
        mv[s][w] = 0; md[s][w] = 0; mt[s][w] = '0;
      end
    end
  endfunction

  function automatic void model_touch(input int s, input int w);
    root[s] = (w < 2) ? 1 : 0;
    if (w < 2) lft[s] = 1 - (w % 2);
    else       rgt[s] = 1 - (w % 2);
  endfunction

  function automatic void model_fill(input int s, input int w, input logic [TAG_W-1:0] t, input logic d);
    mv[s][w] = 1; md[s][w] = d; mt[s][w] = t;
    model_touch(s, w);
  endfunction

  function automatic exp_t model_lookup(input int s, input logic [TAG_W-1:0] t, input logic wr);
    exp_t e;
    int hw = -1;
    int iw = -1;
    int v;
    e = '{hit: 1'b0, way: 2'd0, vway: 2'd0, vdirty: 1'b0, vtag: '0};
    for (int w = 0; w < 4; w++) begin
      if (hw < 0 && mv[s][w] && mt[s][w] == t) hw = w;
      if (iw < 0 && !mv[s][w]) iw = w;
    end
    if (hw >= 0) begin
      e.hit = 1'b1;
      e.way = hw[1:0];
      if (wr) md[s][hw] = 1;
      model_touch(s, hw);
    end else begin
      v        = (iw >= 0) ? iw : ((root[s] == 0) ? lft[s] : 2 + rgt[s]);
      e.vway   = v[1:0];
      e.vdirty = mv[s][v] && md[s][v];
      e.vtag   = mt[s][v];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && bus.resp_valid) begin
      chk("resp_unexpected", q.size() != 0, "resp_valid=1", "no outstanding request");
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        chk("resp",
            (bus.resp_hit == mon_e.hit) &&
            (mon_e.hit ? (bus.resp_way == mon_e.way)
                       : (bus.resp_victim_way == mon_e.vway && bus.resp_victim_dirty == mon_e.vdirty &&
                          bus.resp_victim_tag == mon_e.vtag)),
            $sformatf("hit=%0b way=%0d vway=%0d vdirty=%0b vtag=%h", bus.resp_hit, bus.resp_way,
                      bus.resp_victim_way, bus.resp_victim_dirty, bus.resp_victim_tag),
            $sformatf("hit=%0b way=%0d vway=%0d vdirty=%0b vtag=%h", mon_e.hit, mon_e.way,
                      mon_e.vway, mon_e.vdirty, mon_e.vtag));
      end
    end
  end

  function automatic bit outputs_zero();
    return !bus.tag_en && bus.tag_we == 0 && bus.tag_addr == 0 && bus.tag_wdata == 0 &&
           !bus.req_ready && !bus.fill_ready && !bus.resp_valid && !bus.resp_hit &&
           bus.resp_way == 0 && bus.resp_victim_way == 0 && !bus.resp_victim_dirty &&
           bus.resp_victim_tag == 0;
  endfunction

  function automatic string out_str();
    return $sformatf("en=%0b we=%h addr=%0d wdata=%h rr=%0b fr=%0b rv=%0b", bus.tag_en, bus.tag_we,
                     bus.tag_addr, bus.tag_wdata, bus.req_ready, bus.fill_ready, bus.resp_valid);
  endfunction

  // Entered just after reset release at a falling edge; stop_at >= 0 re-asserts reset there.
  task automatic sweep(input int stop_at);
    for (int i = 0; i < SET_NUM; i++) begin
      #1;
      if (i == stop_at) begin
        rst = 1'b0;
        #1;
        chk("reset_mid_sweep", outputs_zero(), out_str(), "all outputs 0");
        return;
      end
      chk($sformatf("sweep_%0d", i),
          bus.tag_en && bus.tag_we == 4'hF && bus.tag_addr == IW'(i) && bus.tag_wdata == 0 &&
          !bus.req_ready && !bus.fill_ready,
          out_str(), $sformatf("en=1 we=f addr=%0d wdata=0 rr=0 fr=0", i));
      @(negedge clk);
    end
    #1;
    chk("ready_after_sweep", bus.req_ready && bus.fill_ready, out_str(), "rr=1 fr=1");
  endtask

  task automatic release_and_sweep(input int stop_at);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    q.delete();
    sweep(stop_at);
  endtask

  task automatic do_req(input int s, input logic [TAG_W-1:0] t, input logic wr);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_index = IW'(s);
    bus.req_tag   = t;
    bus.req_write = wr;
    #1;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", bus.req_ready, "req_ready=0", "req_ready=1 within 20 cycles");
    else q.push_back(model_lookup(s, t, wr));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic do_fill(input int s, input int w, input logic [TAG_W-1:0] t, input logic d);
    int n = 0;
    @(negedge clk);
    bus.fill_valid = 1'b1;
    bus.fill_index = IW'(s);
    bus.fill_way   = 2'(w);
    bus.fill_tag   = t;
    bus.fill_dirty = d;
    #1;
    while (!bus.fill_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.fill_ready) chk("fill_ready_timeout", bus.fill_ready, "fill_ready=0", "fill_ready=1 within 20 cycles");
    else model_fill(s, w, t, d);
    @(posedge clk);
    #1;
    bus.fill_valid = 1'b0;
  endtask

  task automatic do_collide(input int s, input int w, input logic [TAG_W-1:0] t);
    @(negedge clk);
    bus.fill_valid = 1'b1; bus.fill_index = IW'(s); bus.fill_way = 2'(w);
    bus.fill_tag = t; bus.fill_dirty = 1'b0;
    bus.req_valid = 1'b1; bus.req_index = IW'(s); bus.req_tag = t; bus.req_write = 1'b0;
    #1;
    chk("collide_priority", bus.fill_ready && !bus.req_ready,
        $sformatf("fr=%0b rr=%0b", bus.fill_ready, bus.req_ready), "fr=1 rr=0");
    model_fill(s, w, t, 1'b0);
    @(posedge clk);
    #1;
    bus.fill_valid = 1'b0;
    #1;
    chk("collide_req_ready", bus.req_ready, $sformatf("rr=%0b", bus.req_ready), "rr=1");
    q.push_back(model_lookup(s, t, 1'b0));
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(negedge clk);
    #1;
    chk("queue_drain", q.size() == 0, $sformatf("%0d outstanding", q.size()), "0 outstanding");
  endtask

  localparam logic [TAG_W-1:0] TA = 20'h0A0A0, TB = 20'h0B0B0, TC = 20'h0C0C0, TD = 20'h0D0D0;
  localparam logic [TAG_W-1:0] TE = 20'h0E0E0, TF = 20'h0F0F0, TT = 20'h13579, TX = 20'h2468A;

  initial begin
    bus.req_valid = 0; bus.req_index = '0; bus.req_tag = '0; bus.req_write = 0;
    bus.fill_valid = 0; bus.fill_index = '0; bus.fill_way = '0; bus.fill_tag = '0; bus.fill_dirty = 0;

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", outputs_zero(), out_str(), "all outputs 0");
    release_and_sweep(-1);

    do_req(5, 20'h12345, 1'b0);
    do_fill(5, 0, TA, 1'b0);
    do_fill(5, 1, TB, 1'b0);
    do_fill(5, 2, TC, 1'b0);
    do_fill(5, 3, TD, 1'b0);
    do_req(5, TA, 1'b0);
    do_req(5, TE, 1'b0);

    do_req(5, TB, 1'b1);
    chk("dirty_write",
        bus.tag_en && bus.tag_we == 4'b0010 && bus.tag_addr == 7'd5 &&
        bus.tag_wdata == {2'b11, TB} && !bus.req_ready && !bus.fill_ready,
        out_str(), $sformatf("en=1 we=2 addr=5 wdata=%h rr=0 fr=0", {2'b11, TB}));
    do_req(5, TC, 1'b0);
    do_req(5, TA, 1'b0);
    do_req(5, TD, 1'b0);
    do_req(5, TF, 1'b0);

    do_collide(9, 2, TT);
    drain();

    for (int i = 0; i < 400; i++) begin
      int s = $urandom_range(0, 7);
      logic [TAG_W-1:0] t = 20'hA0000 + 20'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) do_fill(s, $urandom_range(0, 3), t, 1'($urandom_range(0, 1)));
      else                           do_req(s, t, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    drain();

    do_fill(3, 0, TX, 1'b0);
    do_req(3, TX, 1'b1);
    rst = 1'b0;
    q.delete();
    #1;
    chk("reset_drops_dirty", outputs_zero(), out_str(), "all outputs 0");
    release_and_sweep(40);
    release_and_sweep(-1);
    do_req(3, TX, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
